// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the scoreboard and the register file itself.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int DEF_CNT_W = 2;
  localparam int DEF_TOT_W = 6;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/issue/writeback/squash bundle between the pipeline (master) and the scoreboard (slave).
interface regfile_scoreboard_if #(
  parameter int AW    = regfile_pkg::REG_ADDR_W,
  parameter int TOT_W = regfile_pkg::DEF_TOT_W
);
  logic [AW-1:0]    rs_addr;
  logic [AW-1:0]    rt_addr;
  logic             use_rs;
  logic             use_rt;
  logic             issue_valid;
  logic [AW-1:0]    issue_dest;
  logic             issue_ready;
  logic             wb_valid;
  logic [AW-1:0]    wb_reg;
  logic             kill_valid;
  logic [AW-1:0]    kill_dest;
  logic             stall;
  logic [TOT_W-1:0] pending_total;
  logic             err_underflow;

  modport master (
    output rs_addr, rt_addr, use_rs, use_rt, issue_valid, issue_dest,
           wb_valid, wb_reg, kill_valid, kill_dest,
    input  issue_ready, stall, pending_total, err_underflow
  );

  modport slave (
    input  rs_addr, rt_addr, use_rs, use_rt, issue_valid, issue_dest,
           wb_valid, wb_reg, kill_valid, kill_dest,
    output issue_ready, stall, pending_total, err_underflow
  );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: saturating increment, decrements clamp at zero.
// Wb and kill on the same edge net out in one step; excess decrements raise underflow.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             full,
  output logic             underflow
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W:0] cur;
  logic [CNT_W:0] req;
  logic [CNT_W:0] eff;

  always_comb begin
    full      = (cnt == MAX);
    cur       = {1'b0, cnt};
    req       = (CNT_W+1)'(dec_wb) + (CNT_W+1)'(dec_kill);
    underflow = (req > cur);
    eff       = underflow ? cur : req;
    cnt_nxt   = CNT_W'(cur + (CNT_W+1)'(inc && !full) - eff);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// RAW-hazard scoreboard for the register file: holds decode while a source has a pending writer.
// No bypass: stall releases the cycle after the last pending write lands in the register file.
module regfile_scoreboard #(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int CNT_W = regfile_pkg::DEF_CNT_W,
  parameter int TOT_W = regfile_pkg::DEF_TOT_W
) (
  input  logic           clk,
  input  logic           reset,
  regfile_scoreboard_if.slave sb
);
  import regfile_pkg::*;

  localparam int AW    = $clog2(NREGS);
  localparam int SUM_W = AW + CNT_W;
  localparam int TOT_MAX = 2**TOT_W - 1;

  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [NREGS-1:0] full;
  logic [NREGS-1:0] uf;
  logic [SUM_W-1:0] sum;
  logic [TOT_W-1:0] tot_nxt;
  logic             issue_ok;

  // r0 never tracks anything, so it reads as an always-empty counter.
  assign cnt[0]     = '0;
  assign cnt_nxt[0] = '0;
  assign full[0]    = 1'b0;
  assign uf[0]      = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (issue_ok && sb.issue_dest == AW'(r)),
      .dec_wb    (sb.wb_valid && sb.wb_reg == AW'(r)),
      .dec_kill  (sb.kill_valid && sb.kill_dest == AW'(r)),
      .cnt       (cnt[r]),
      .cnt_nxt   (cnt_nxt[r]),
      .full      (full[r]),
      .underflow (uf[r])
    );
  end

  assign sb.issue_ready = (sb.issue_dest == REG_ZERO) || !full[sb.issue_dest];
  assign issue_ok       = sb.issue_valid && sb.issue_ready;

  assign sb.stall = (sb.use_rs && sb.rs_addr != REG_ZERO && cnt[sb.rs_addr] != '0)
                 || (sb.use_rt && sb.rt_addr != REG_ZERO && cnt[sb.rt_addr] != '0)
                 || (sb.issue_valid && !sb.issue_ready);

  always_comb begin
    sum = '0;
    for (int r = 0; r < NREGS; r++) sum = sum + SUM_W'(cnt_nxt[r]);
    tot_nxt = (int'(sum) > TOT_MAX) ? TOT_W'(TOT_MAX) : TOT_W'(sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb.pending_total <= '0;
      sb.err_underflow <= 1'b0;
    end else begin
      sb.pending_total <= tot_nxt;
      sb.err_underflow <= sb.err_underflow | (|uf);
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scenario tasks plus a randomized run against a per-register pending-count model.
module tb_regfile_scoreboard;
  localparam int MAXC = 3;
  localparam int TOTMAX = 63;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.AW(5), .TOT_W(6)) sb ();

  regfile_scoreboard #(.NREGS(32), .CNT_W(2), .TOT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb.slave)
  );

  int checks = 0;
  int failures = 0;
  int mcnt [32];
  int mtot;
  bit merr;

  function automatic bit exp_ready();
    return (sb.issue_dest == 5'd0) || (mcnt[sb.issue_dest] < MAXC);
  endfunction

  function automatic bit exp_stall();
    bit s;
    s = 1'b0;
    if (sb.use_rs && sb.rs_addr != 0 && mcnt[sb.rs_addr] > 0) s = 1'b1;
    if (sb.use_rt && sb.rt_addr != 0 && mcnt[sb.rt_addr] > 0) s = 1'b1;
    if (sb.issue_valid && !exp_ready()) s = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    mtot = 0;
    merr = 1'b0;
  endtask

  task automatic model_edge();
    int sum;
    int inc;
    int dec;
    sum = 0;
    for (int r = 1; r < 32; r++) begin
      inc = (sb.issue_valid && sb.issue_dest == r && mcnt[r] < MAXC) ? 1 : 0;
      dec = ((sb.wb_valid && sb.wb_reg == r) ? 1 : 0) + ((sb.kill_valid && sb.kill_dest == r) ? 1 : 0);
      if (dec > mcnt[r]) begin
        merr = 1'b1;
        dec = mcnt[r];
      end
      mcnt[r] = mcnt[r] + inc - dec;
      sum += mcnt[r];
    end
    mtot = (sum > TOTMAX) ? TOTMAX : sum;
  endtask

  task automatic drive(input logic iv, input logic [4:0] id, input logic wv, input logic [4:0] wr,
                       input logic kv, input logic [4:0] kd, input logic urs, input logic [4:0] rs,
                       input logic urt, input logic [4:0] rt);
    @(negedge clk);
    sb.issue_valid = iv; sb.issue_dest = id;
    sb.wb_valid = wv;    sb.wb_reg = wr;
    sb.kill_valid = kv;  sb.kill_dest = kd;
    sb.use_rs = urs;     sb.rs_addr = rs;
    sb.use_rt = urt;     sb.rt_addr = rt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (sb.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", sb.stall); end
    checks++; if (sb.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", sb.issue_ready); end
    checks++; if (sb.pending_total !== 6'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", sb.pending_total); end
    checks++; if (sb.err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", sb.err_underflow); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_raw();
    drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (sb.stall !== 1'b0) begin failures++; $display("FAIL raw_issue_stall got=%0b exp=0", sb.stall); end
    tick();
    checks++; if (sb.pending_total !== 6'd1) begin failures++; $display("FAIL raw_total got=%0d exp=1", sb.pending_total); end
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    checks++; if (sb.stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%0b exp=1", sb.stall); end
    tick();
    drive(0, 0, 1, 9, 0, 0, 1, 9, 0, 0);
    checks++; if (sb.stall !== 1'b1) begin failures++; $display("FAIL raw_wb_cycle_stall got=%0b exp=1", sb.stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    checks++; if (sb.stall !== 1'b0) begin failures++; $display("FAIL raw_release got=%0b exp=0", sb.stall); end
    checks++; if (sb.pending_total !== 6'd0) begin failures++; $display("FAIL raw_total_clr got=%0d exp=0", sb.pending_total); end
    tick();
  endtask

  task automatic test_same_cycle();
    drive(1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 10, 1, 10, 0, 0, 1, 10, 0, 0);
    checks++; if (sb.stall !== 1'b1) begin failures++; $display("FAIL same_stall got=%0b exp=1", sb.stall); end
    tick();
    checks++; if (sb.pending_total !== 6'd1) begin failures++; $display("FAIL same_total got=%0d exp=1", sb.pending_total); end
    drive(0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
    checks++; if (sb.stall !== 1'b1) begin failures++; $display("FAIL same_hold got=%0b exp=1", sb.stall); end
    tick();
    drive(0, 0, 1, 10, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (sb.pending_total !== 6'd0) begin failures++; $display("FAIL same_clr got=%0d exp=0", sb.pending_total); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      drive(1, 11, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    checks++; if (sb.pending_total !== 6'd3) begin failures++; $display("FAIL sat_total got=%0d exp=3", sb.pending_total); end
    drive(1, 11, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (sb.issue_ready !== 1'b0) begin failures++; $display("FAIL sat_ready got=%0b exp=0", sb.issue_ready); end
    checks++; if (sb.stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%0b exp=1", sb.stall); end
    tick();
    checks++; if (sb.pending_total !== 6'd3) begin failures++; $display("FAIL sat_drop got=%0d exp=3", sb.pending_total); end
    drive(0, 11, 1, 11, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 11, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (sb.issue_ready !== 1'b1) begin failures++; $display("FAIL sat_ready_back got=%0b exp=1", sb.issue_ready); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 11, 0, 0, 0, 0, 0, 0);
      tick();
    end
    checks++; if (sb.pending_total !== 6'd0) begin failures++; $display("FAIL sat_clr got=%0d exp=0", sb.pending_total); end
  endtask

  task automatic test_zero();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (sb.stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%0b exp=0", sb.stall); end
    checks++; if (sb.issue_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%0b exp=1", sb.issue_ready); end
    tick();
    checks++; if (sb.pending_total !== 6'd0) begin failures++; $display("FAIL zero_total got=%0d exp=0", sb.pending_total); end
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (sb.err_underflow !== 1'b0) begin failures++; $display("FAIL zero_err got=%0b exp=0", sb.err_underflow); end
  endtask

  task automatic test_kill_underflow();
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 8, 0, 0, 0, 0);
    tick();
    checks++; if (sb.pending_total !== 6'd0) begin failures++; $display("FAIL kill_total got=%0d exp=0", sb.pending_total); end
    checks++; if (sb.err_underflow !== 1'b0) begin failures++; $display("FAIL kill_err got=%0b exp=0", sb.err_underflow); end
    drive(0, 0, 1, 8, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (sb.err_underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%0b exp=1", sb.err_underflow); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    checks++; if (sb.err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0b exp=1", sb.err_underflow); end
  endtask

  task automatic test_reset_mid();
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 8, 0, 0);
    checks++; if (sb.pending_total !== 6'd2) begin failures++; $display("FAIL mid_total got=%0d exp=2", sb.pending_total); end
    checks++; if (sb.stall !== 1'b1) begin failures++; $display("FAIL mid_stall got=%0b exp=1", sb.stall); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (sb.stall !== 1'b0) begin failures++; $display("FAIL arst_stall got=%0b exp=0", sb.stall); end
    checks++; if (sb.pending_total !== 6'd0) begin failures++; $display("FAIL arst_total got=%0d exp=0", sb.pending_total); end
    checks++; if (sb.err_underflow !== 1'b0) begin failures++; $display("FAIL arst_err got=%0b exp=0", sb.err_underflow); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_total_sat();
    for (int round = 0; round < 3; round++) begin
      for (int r = 1; r < 32; r++) begin
        drive(1, 5'(r), 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (sb.issue_ready !== exp_ready()) begin failures++; $display("FAIL tsat_ready r=%0d got=%0b exp=%0b", r, sb.issue_ready, exp_ready()); end
        tick();
        checks++; if (sb.pending_total !== 6'(mtot)) begin failures++; $display("FAIL tsat_total r=%0d got=%0d exp=%0d", r, sb.pending_total, mtot); end
      end
    end
    checks++; if (sb.pending_total !== 6'd63) begin failures++; $display("FAIL tsat_final got=%0d exp=63", sb.pending_total); end
    do_reset();
  endtask

  task automatic test_random();
    logic kv;
    logic [4:0] wr;
    logic [4:0] kd;
    for (int i = 0; i < 400; i++) begin
      wr = 5'($urandom_range(0, 7));
      kd = 5'($urandom_range(0, 7));
      kv = ($urandom_range(0, 5) == 0);
      if (kd == wr) kv = 1'b0;
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), wr, kv, kd,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      checks++; if (sb.stall !== exp_stall()) begin failures++; $display("FAIL rnd_stall i=%0d got=%0b exp=%0b", i, sb.stall, exp_stall()); end
      checks++; if (sb.issue_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, sb.issue_ready, exp_ready()); end
      tick();
      checks++; if (sb.pending_total !== 6'(mtot)) begin failures++; $display("FAIL rnd_total i=%0d got=%0d exp=%0d", i, sb.pending_total, mtot); end
      checks++; if (sb.err_underflow !== merr) begin failures++; $display("FAIL rnd_err i=%0d got=%0b exp=%0b", i, sb.err_underflow, merr); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw();
    test_same_cycle();
    test_saturation();
    test_zero();
    test_kill_underflow();
    test_reset_mid();
    test_total_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
